status_reg_stack: RTL and testbench

- Parametrised CPU status register (SR) with a hardware save/restore stack for interrupt entry and return.
- Supports four update sources: full masked write (MOV to SR), ALU flag update under mask, single-bit set/clear (SEI/CLI-style), and restore from the stack.
- Sits beside the ALU and control unit. The control unit drives push on interrupt entry and pop on return.

---
 rtl/cpu_sr_pkg.sv | 15 +
 rtl/sr_lifo.sv | 50 +++++
 rtl/status_reg_stack.sv | 97 +++++++++
 tb/tb_status_reg_stack.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_sr_pkg.sv
// Shared status-register definitions: bit positions, default sizes and the SR type.
package cpu_sr_pkg;

    localparam int SR_WIDTH = 8;
    localparam int SR_DEPTH = 4;

    localparam int SR_C = 0;
    localparam int SR_Z = 1;
    localparam int SR_N = 2;
    localparam int SR_V = 3;
    localparam int SR_I = 7;

    typedef logic [SR_WIDTH-1:0] sr_t;

endpackage

// File: rtl/sr_lifo.sv
// DEPTH x WIDTH register stack with saturating occupancy count.
// Simultaneous push and pop is treated as a no-op.
module sr_lifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] depth,
    output logic             full,
    output logic             empty,
    output logic             push_ok,
    output logic             pop_ok
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] top_idx;

    assign full    = (depth == CNT_W'(DEPTH));
    assign empty   = (depth == '0);
    assign push_ok = push & ~pop & ~full;
    assign pop_ok  = pop & ~push & ~empty;
    assign top_idx = depth - CNT_W'(1);
    assign dout    = empty ? '0 : mem[top_idx[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            depth <= '0;
        end else if (push_ok) begin
            depth <= depth + CNT_W'(1);
        end else if (pop_ok) begin
            depth <= depth - CNT_W'(1);
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem[depth[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/status_reg_stack.sv
// CPU status register with masked write, ALU flag merge, bit set/clear and a
// hardware save stack for interrupt entry/return, plus sticky stack errors.
module status_reg_stack
    import cpu_sr_pkg::*;
#(
    parameter int               WIDTH     = SR_WIDTH,
    parameter int               DEPTH     = SR_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int               CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_mask,
    input  logic             flag_upd,
    input  logic [WIDTH-1:0] flag_data,
    input  logic [WIDTH-1:0] flag_mask,
    input  logic             bit_set,
    input  logic             bit_clr,
    input  logic [IDX_W-1:0] bit_idx,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clr,
    output logic [WIDTH-1:0] sr_q,
    output logic [CNT_W-1:0] depth,
    output logic             full,
    output logic             empty,
    output logic             err_ovf,
    output logic             err_unf
);

    logic [WIDTH-1:0] stack_top;
    logic [WIDTH-1:0] sr_next;
    logic             push_ok;
    logic             pop_ok;
    logic             idx_ok;

    sr_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_lifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .din     (sr_q),
        .dout    (stack_top),
        .depth   (depth),
        .full    (full),
        .empty   (empty),
        .push_ok (push_ok),
        .pop_ok  (pop_ok)
    );

    // Only a non-power-of-two width can present an index past the top bit.
    if ((2 ** IDX_W) > WIDTH) begin : g_idx_chk
        assign idx_ok = (32'(bit_idx) < WIDTH);
    end else begin : g_idx_all
        assign idx_ok = 1'b1;
    end

    // Later stages override earlier ones; a valid pop discards all of them.
    always_comb begin
        sr_next = sr_q;
        if (flag_upd) begin
            sr_next = (sr_next & ~flag_mask) | (flag_data & flag_mask);
        end
        if (wr_en) begin
            sr_next = (sr_next & ~wr_mask) | (wr_data & wr_mask);
        end
        if (bit_set && idx_ok) begin
            sr_next[bit_idx] = 1'b1;
        end
        if (bit_clr && idx_ok) begin
            sr_next[bit_idx] = 1'b0;
        end
        if (pop_ok) begin
            sr_next = stack_top;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_q    <= RESET_VAL;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            sr_q    <= sr_next;
            err_ovf <= (err_ovf & ~err_clr) | (push & ~pop & full);
            err_unf <= (err_unf & ~err_clr) | (pop & ~push & empty);
        end
    end

endmodule

// File: tb/tb_status_reg_stack.sv
// Directed bench for status_reg_stack with default parameters (8-bit SR, 4-deep stack).
module tb_status_reg_stack;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] wr_mask;
    logic       flag_upd;
    logic [7:0] flag_data;
    logic [7:0] flag_mask;
    logic       bit_set;
    logic       bit_clr;
    logic [2:0] bit_idx;
    logic       push;
    logic       pop;
    logic       err_clr;
    logic [7:0] sr_q;
    logic [2:0] depth;
    logic       full;
    logic       empty;
    logic       err_ovf;
    logic       err_unf;

    int n_assert = 0;
    int n_fail   = 0;

    status_reg_stack dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
        .flag_upd  (flag_upd),
        .flag_data (flag_data),
        .flag_mask (flag_mask),
        .bit_set   (bit_set),
        .bit_clr   (bit_clr),
        .bit_idx   (bit_idx),
        .push      (push),
        .pop       (pop),
        .err_clr   (err_clr),
        .sr_q      (sr_q),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf)
    );

    always #5 clk = ~clk;

    task automatic idle();
        wr_en = 0; wr_data = '0; wr_mask = '0;
        flag_upd = 0; flag_data = '0; flag_mask = '0;
        bit_set = 0; bit_clr = 0; bit_idx = '0;
        push = 0; pop = 0; err_clr = 0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_sr(input logic [7:0] v);
        idle(); wr_en = 1; wr_data = v; wr_mask = 8'hFF;
        tick();
    endtask

    initial begin
        idle();
        rst = 0;
        #1;
        // 1. reset and ALU update
        tick(); tick();
        chk("rst_sr", sr_q, 8'h00);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_depth", depth, 0);
        chk("rst_errs", {err_ovf, err_unf}, 2'b00);
        rst = 1;
        flag_upd = 1; flag_data = 8'hFF; flag_mask = 8'h0F;
        tick();
        chk("alu_upd", sr_q, 8'h0F);

        // 2. write vs flag collision, then set/clr on the same bit
        idle();
        wr_en = 1; wr_data = 8'h00; wr_mask = 8'h03;
        flag_upd = 1; flag_data = 8'hFF; flag_mask = 8'h03;
        tick();
        chk("wr_over_flag", sr_q, 8'h0C);
        idle(); bit_set = 1; bit_clr = 1; bit_idx = 3'd2;
        tick();
        chk("clr_over_set", sr_q, 8'h08);
        idle(); bit_set = 1; bit_idx = 3'd0;
        tick();
        chk("bit_set", sr_q, 8'h09);

        // 3. interrupt entry and return
        write_sr(8'h05);
        chk("pre_irq", sr_q, 8'h05);
        idle(); push = 1; bit_set = 1; bit_idx = 3'd7;
        tick();
        chk("irq_sr", sr_q, 8'h85);
        chk("irq_depth", depth, 1);
        chk("irq_empty", empty, 0);
        write_sr(8'h00);
        chk("isr_wr", sr_q, 8'h00);
        idle(); pop = 1;
        tick();
        chk("reti_sr", sr_q, 8'h05);
        chk("reti_depth", depth, 0);
        chk("reti_empty", empty, 1);

        // 4. overflow: push saves the pre-update SR while the write loads the next value
        write_sr(8'h01);
        for (int v = 2; v <= 4; v++) begin
            idle(); push = 1; wr_en = 1; wr_data = 8'(v); wr_mask = 8'hFF;
            tick();
        end
        idle(); push = 1;
        tick();
        chk("fill_depth", depth, 4);
        chk("fill_full", full, 1);
        chk("fill_ovf", err_ovf, 0);
        idle(); push = 1; wr_en = 1; wr_data = 8'h55; wr_mask = 8'hFF;
        tick();
        chk("ovf_depth", depth, 4);
        chk("ovf_flag", err_ovf, 1);
        chk("ovf_sr", sr_q, 8'h55);
        for (int v = 4; v >= 1; v--) begin
            idle(); pop = 1;
            tick();
            chk("lifo_sr", sr_q, 32'(v));
            chk("lifo_depth", depth, 32'(v - 1));
        end
        chk("lifo_empty", empty, 1);
        chk("ovf_sticky", err_ovf, 1);
        idle(); err_clr = 1;
        tick();
        chk("ovf_clr", err_ovf, 0);

        // 5. underflow, then push and pop together
        idle(); pop = 1; wr_en = 1; wr_data = 8'hAA; wr_mask = 8'hFF;
        tick();
        chk("unf_sr", sr_q, 8'hAA);
        chk("unf_flag", err_unf, 1);
        chk("unf_depth", depth, 0);
        idle(); err_clr = 1;
        tick();
        chk("unf_clr", err_unf, 0);
        idle(); pop = 1; err_clr = 1;
        tick();
        chk("unf_set_wins", err_unf, 1);
        idle(); err_clr = 1;
        tick();
        idle(); push = 1;
        tick(); tick();
        chk("pp_pre_depth", depth, 2);
        idle(); push = 1; pop = 1;
        tick();
        chk("pp_depth", depth, 2);
        chk("pp_sr", sr_q, 8'hAA);
        chk("pp_errs", {err_ovf, err_unf}, 2'b00);
        idle(); push = 1; pop = 1; bit_clr = 1; bit_idx = 3'd1;
        tick();
        chk("pp_stage_sr", sr_q, 8'hA8);
        chk("pp_stage_depth", depth, 2);

        // 6. reset mid-operation at depth 3 with err_ovf set
        idle(); push = 1;
        tick(); tick(); tick();
        chk("ovf2_flag", err_ovf, 1);
        idle(); pop = 1;
        tick();
        chk("mid_depth", depth, 3);
        idle(); rst = 0; push = 1;
        tick();
        chk("mid_rst_sr", sr_q, 8'h00);
        chk("mid_rst_depth", depth, 0);
        chk("mid_rst_ovf", err_ovf, 0);
        chk("mid_rst_empty", empty, 1);
        idle(); rst = 1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
